// File: rtl/mem_bus_master_if.sv
// Signal bundle between a request/response client, mem_bus_master and the memory bus.
// Both handshakes transfer on a rising edge where valid && ready; valid holds its payload stable until then.
interface mem_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              read;
    logic              write;
    logic              enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               read, write, enable, address, wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               read, write, enable, address, wdata
    );
endinterface

// File: rtl/mem_bus_master.sv
// Buffers read/write requests in a small FIFO and issues each as a one-cycle memory bus access,
// returning one in-order response per request; out-of-range addresses are answered with an error.
module mem_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_bus_master_if.master       bus,
    output logic                   busy,
    output logic [15:0]            txn_count,
    output logic [1:0]             state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic              enable_q;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [15:0]       txn_q;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q;
    logic [PW:0]       rd_ptr_q;
    logic [PW:0]       wr_ptr_d;
    logic [PW:0]       rd_ptr_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_in_range;

    // The extra MSB on each pointer separates full (MSBs differ) from empty (MSBs equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign bus.req_ready = rst_n && !fifo_full;
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state_q == IDLE) && !fifo_empty;

    assign head          = fifo_mem[rd_ptr_q[PW-1:0]];
    assign head_write    = head[EW-1];
    assign head_addr     = head[ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata    = head[DATA_W-1:0];
    assign head_in_range = (32'(head_addr) < 32'(MEM_DEPTH));

    assign wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {bus.req_write, bus.req_addr, bus.req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            txn_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_in_range) begin
                            state_q   <= ACCESS;
                            enable_q  <= 1'b1;
                            read_q    <= !head_write;
                            write_q   <= head_write;
                            address_q <= head_addr;
                            wdata_q   <= head_wdata;
                        end else begin
                            // Rejected request: answer directly, the bus stays quiet.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= head_write;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    enable_q    <= 1'b0;
                    read_q      <= 1'b0;
                    write_q     <= 1'b0;
                    address_q   <= '0;
                    wdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= write_q;
                    rsp_rdata_q <= read_q ? bus.rdata : '0;
                    rsp_err_q   <= 1'b0;
                    txn_q       <= txn_q + 16'd1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.enable    = enable_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.address   = address_q;
    assign bus.wdata     = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign busy      = !fifo_empty || (state_q != IDLE);
    assign txn_count = txn_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: small memory model on the bus, in-order response scoreboard.
module tb_mem_bus_master;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RW     = 2 + DATA_W;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] txn_count;
    logic [1:0]  state_dbg;

    mem_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy), .txn_count(txn_count), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int enable_cycles = 0;
    int rsp_count = 0;
    logic mon_on = 1'b0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Memory model: contents reload while reset is held.
    logic [7:0] mem_model [8];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_model[0] <= 8'd40; mem_model[1] <= 8'd21;
            mem_model[2] <= 8'd42; mem_model[3] <= 8'd35;
            mem_model[4] <= 8'd46; mem_model[5] <= 8'd50;
            mem_model[6] <= 8'd77; mem_model[7] <= 8'd63;
        end else if (bus.enable && bus.write) begin
            mem_model[bus.address[2:0]] <= bus.wdata;
        end
    end
    assign bus.rdata = (bus.enable && bus.read) ? mem_model[bus.address[2:0]] : '0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.enable) enable_cycles++;
            check("rw_excl", 32'(bus.read && bus.write), 0);
            check("bus_idle", 32'(!bus.enable && (bus.read || bus.write ||
                  bus.address != 0 || bus.wdata != 0)), 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                check("rsp_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("rsp_data", 32'({bus.rsp_err, bus.rsp_write, bus.rsp_rdata}),
                          32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic seen;
        seen = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.req_ready;
        end
        check("push_accept", 32'(seen), 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        check("drain", 32'(done), 1);
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int en_base;
        int rsp_base;
        logic seen;
        logic [7:0] rd_vals [5];
        rd_vals = '{8'd40, 8'd21, 8'd42, 8'd35, 8'd46};

        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_addr  = '0;   bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_bus", 32'({bus.enable, bus.read, bus.write, bus.address, bus.wdata}), 0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_txn", 32'(txn_count), 0);
        check("rst_state", 32'(state_dbg), 0);
        #2 rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 32'(bus.req_ready), 1);
        tick();

        // Read addr 3: bus access in the cycle after accept, response one cycle later.
        push_req(1'b0, 8'd3, 8'd0);
        exp_q.push_back({1'b0, 1'b0, 8'd35});
        en_base = enable_cycles;
        check("t1_idle_en", 32'(bus.enable), 0);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_strobes", 32'({bus.enable, bus.read, bus.write}), 3'b110);
        check("t1_addr", 32'(bus.address), 3);
        check("t1_rv_early", 32'(bus.rsp_valid), 0);
        tick();
        check("t1_en_off", 32'(bus.enable), 0);
        check("t1_rv", 32'(bus.rsp_valid), 1);
        check("t1_rdata", 32'(bus.rsp_rdata), 35);
        check("t1_err", 32'(bus.rsp_err), 0);
        check("t1_txn", 32'(txn_count), 1);
        check("t1_en_cycles", 32'(enable_cycles - en_base), 1);
        drain();

        // Write addr 5 = 99, then read it back through the memory model.
        push_req(1'b1, 8'd5, 8'd99);
        exp_q.push_back({1'b0, 1'b1, 8'd0});
        tick();
        check("t2_strobes", 32'({bus.enable, bus.read, bus.write}), 3'b101);
        check("t2_addr", 32'(bus.address), 5);
        check("t2_wdata", 32'(bus.wdata), 99);
        tick();
        check("t2_rv", 32'(bus.rsp_valid), 1);
        check("t2_rsp_write", 32'(bus.rsp_write), 1);
        check("t2_rdata", 32'(bus.rsp_rdata), 0);
        check("t2_txn", 32'(txn_count), 2);
        drain();
        push_req(1'b0, 8'd5, 8'd0);
        exp_q.push_back({1'b0, 1'b0, 8'd99});
        drain();
        check("t2_txn_rb", 32'(txn_count), 3);

        // Out-of-range read: error response one cycle after accept, no bus access.
        push_req(1'b0, 8'd8, 8'd0);
        exp_q.push_back({1'b1, 1'b0, 8'd0});
        en_base = enable_cycles;
        tick();
        check("t3_rv", 32'(bus.rsp_valid), 1);
        check("t3_err", 32'(bus.rsp_err), 1);
        check("t3_rdata", 32'(bus.rsp_rdata), 0);
        check("t3_en", 32'(bus.enable), 0);
        drain();
        check("t3_en_cycles", 32'(enable_cycles - en_base), 0);
        check("t3_txn", 32'(txn_count), 3);

        // Back-pressure: the first request is popped into the stalled response stage,
        // so five back-to-back pushes fit (one in flight + four buffered) before full.
        for (int i = 0; i < 5; i++) begin
            push_req(1'b0, 8'(i), 8'd0);
            exp_q.push_back({1'b0, 1'b0, rd_vals[i]});
        end
        @(negedge clk);
        check("t4_full", 32'(bus.req_ready), 0);
        check("t4_stall_rv", 32'(bus.rsp_valid), 1);
        check("t4_txn", 32'(txn_count), 4);
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = 8'd6; bus.req_wdata = 8'd0;
        exp_q.push_back({1'b0, 1'b0, 8'd77});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_blocked", 32'(bus.req_ready), 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.req_ready;
        end
        check("t4_slot_freed", 32'(seen), 1);
        tick();
        bus.req_valid = 1'b0;
        drain();
        check("t4_txn_end", 32'(txn_count), 9);

        // Reset during the ACCESS cycle of a queued burst.
        bus.rsp_ready = 1'b1;
        push_req(1'b0, 8'd1, 8'd0);
        bus.req_valid = 1'b1; bus.req_addr = 8'd2;
        tick();
        bus.req_valid = 1'b0;
        check("t5_in_access", 32'(bus.enable), 1);
        rsp_base = rsp_count;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_drop", 32'({bus.enable, bus.read, bus.write}), 0);
        check("t5_rv", 32'(bus.rsp_valid), 0);
        check("t5_req_ready", 32'(bus.req_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_txn", 32'(txn_count), 0);
        check("t5_no_rsp", 32'(rsp_count - rsp_base), 0);
        check("t5_state", 32'(state_dbg), 0);
        check("t5_req_ready_rel", 32'(bus.req_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
